control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired Moore control unit for the datapath.
- Generates every per-cycle strobe that the datapath's bus and registers consume: the PC/MAR/MDR/IR/Y/Z/HI/LO enables, the bus-source selects, and the ALU opcode.
- Runs a fixed fetch sequence (T0–T2), decodes the IR contents, then sequences execute steps (T3–T6) per instruction class.
- The IR register itself lives in the datapath; its output feeds back here.

Parameters:
- NREG, 16, number of general registers; width of the one-hot R_out/R_enable vectors.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  asynchronous, active-low reset.
- ir  input  32  datapath IR contents. Fields: op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out  output  1 each  bus-source selects.
- R_out  output  NREG  one-hot register bus-source select.
- R_enable  output  NREG  one-hot register load enable.
- MAR_enable, PC_enable, IncPC, Read, MDR_enable, IR_enable, Y_enable, Z_enable, HI_enable, LO_enable  output  1 each  load/control strobes.
- opcode  output  5  ALU operation; equals op during the ALU step, 0 otherwise.
- run  output  1  high unless halted or in reset.
- illegal  output  1  one-cycle pulse on an undefined op.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- **Reset**
  - clr low asynchronously forces state=IDLE, instr_count=0, and every output 0 (including run).
  - After clr rises: IDLE→T0 on the next edge.
- **Output timing**
  - All outputs decode only from the registered state and the registered ir. No output depends combinationally on clr beyond the reset clear.
  - At most one bus-source select is high in any state.
- **Fetch (common to all instructions)**
  - T0: PC_out, MAR_enable, IncPC, PC_enable.
  - T1: Read, MDR_enable.
  - T2: MDR_out, IR_enable.
  - ir is sampled for decode from T3 onward, i.e. the value loaded at the end of T2.
- **Three-register ALU, op 00011–01100** (add, sub, shr, shl, ror, rol, and, or, shra, addi-reserved-as-reg)
  - T3: R_out[rb], Y_enable.
  - T4: R_out[rc], opcode=op, Z_enable.
  - T5: ZLow_out, R_enable[ra]; then T0.
- **mul 01111 / div 10000**
  - T3: R_out[ra], Y_enable.
  - T4: R_out[rb], opcode=op, Z_enable.
  - T5: ZLow_out, LO_enable.
  - T6: ZHigh_out, HI_enable; then T0.
- **neg 10001 / not 10010**
  - T3: R_out[rb], opcode=op, Z_enable.
  - T4: ZLow_out, R_enable[ra]; then T0.
- **mfhi 10111 / mflo 11000**
  - T3: HI_out (or LO_out), R_enable[ra]; then T0.
- **nop 11010:** T3 asserts nothing; then T0.
- **halt 11011:** T3→HALT. HALT holds all outputs 0 and run=0 until clr.
- **Any other op:** T3 pulses illegal for one cycle and otherwise behaves as nop.
- **Instruction counter**
  - instr_count increments by 1 on the edge leaving the final execute state of any instruction (including nop and illegal; excluding halt).
  - Wraps 2^CNT_W−1 → 0.
- **Register select**
  - R_out and R_enable are one-hot decodes of the 4-bit field.
  - Register 0 is not special-cased.
  - When ra equals rb or rc there is no conflict, since the read and write occur in different states.
- **Reset mid-instruction:** aborts immediately. No partial strobe survives the clr assertion, and the counter is not incremented.

Test Plan:
- Reset then release; ir=0x20228000 (sub R0,R4,R5).
  - T0–T2 strobes as specified.
  - T3: R_out=0x0010, Y_enable.
  - T4: R_out=0x0020, opcode=00100, Z_enable.
  - T5: ZLow_out, R_enable=0x0001.
  - Back to T0; instr_count=1.
- ir op=01111 (mul), ra=2, rb=3.
  - T3 R_out=0x0004; T4 R_out=0x0008 with Z_enable.
  - T5 LO_enable; T6 ZHigh_out+HI_enable.
  - Total 7 cycles from T0.
- ir op=11000 (mflo), ra=7: T3 LO_out with R_enable=0x0080; the next cycle is T0.
- ir op=11111 → illegal high for exactly one cycle in T3; no enables asserted; instr_count increments.
- ir op=11011 (halt) → run falls after T3 and all outputs stay 0 for 20 cycles; clr pulse low then high → IDLE, then T0, run=1.
- Assert clr low during T4 of an add → all outputs 0 in the same cycle without waiting for clk; instr_count=0. Preload instr_count to 0xFFFF via repeated nops → the next retire reads 0x0000.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch (T0-T2), decode the datapath IR, then
// sequence the execute steps (T3-T6) for each instruction class.
module control_unit #(
  parameter int NREG  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  output logic             PC_out,
  output logic             MDR_out,
  output logic             ZLow_out,
  output logic             ZHigh_out,
  output logic             HI_out,
  output logic             LO_out,
  output logic [NREG-1:0]  R_out,
  output logic [NREG-1:0]  R_enable,
  output logic             MAR_enable,
  output logic             PC_enable,
  output logic             IncPC,
  output logic             Read,
  output logic             MDR_enable,
  output logic             IR_enable,
  output logic             Y_enable,
  output logic             Z_enable,
  output logic             HI_enable,
  output logic             LO_enable,
  output logic [4:0]       opcode,
  output logic             run,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  localparam logic [2:0] C_ALU  = 3'd0;
  localparam logic [2:0] C_MD   = 3'd1;
  localparam logic [2:0] C_NN   = 3'd2;
  localparam logic [2:0] C_MFHI = 3'd3;
  localparam logic [2:0] C_MFLO = 3'd4;
  localparam logic [2:0] C_NOP  = 3'd5;
  localparam logic [2:0] C_HALT = 3'd6;
  localparam logic [2:0] C_ILL  = 3'd7;

  logic [3:0]       state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic             retire;
  logic [4:0]       op;
  logic [3:0]       ra, rb, rc;
  logic [2:0]       cls;
  logic             r_out_on, r_en_on;
  logic [3:0]       r_out_idx, r_en_idx;
  logic             unused_ir_bits;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused_ir_bits = ^ir[14:0];

  always_comb begin
    cls = C_ILL;
    if (op inside {[5'd3:5'd12]})            cls = C_ALU;
    else if (op == 5'd15 || op == 5'd16)     cls = C_MD;
    else if (op == 5'd17 || op == 5'd18)     cls = C_NN;
    else if (op == 5'd23)                    cls = C_MFHI;
    else if (op == 5'd24)                    cls = C_MFLO;
    else if (op == 5'd26)                    cls = C_NOP;
    else if (op == 5'd27)                    cls = C_HALT;
  end

  // retire marks the final execute step of the current instruction class
  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      S_IDLE: state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1:   state_next = S_T2;
      S_T2:   state_next = S_T3;
      S_T3: begin
        if (cls == C_HALT) begin
          state_next = S_HALT;
        end else if (cls inside {C_MFHI, C_MFLO, C_NOP, C_ILL}) begin
          state_next = S_T0;
          retire     = 1'b1;
        end else begin
          state_next = S_T4;
        end
      end
      S_T4: begin
        if (cls == C_NN) begin
          state_next = S_T0;
          retire     = 1'b1;
        end else begin
          state_next = S_T5;
        end
      end
      S_T5: begin
        if (cls == C_ALU) begin
          state_next = S_T0;
          retire     = 1'b1;
        end else begin
          state_next = S_T6;
        end
      end
      S_T6: begin
        state_next = S_T0;
        retire     = 1'b1;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign instr_count = count_reg;

  always_comb begin
    PC_out     = 1'b0;
    MDR_out    = 1'b0;
    ZLow_out   = 1'b0;
    ZHigh_out  = 1'b0;
    HI_out     = 1'b0;
    LO_out     = 1'b0;
    MAR_enable = 1'b0;
    PC_enable  = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    MDR_enable = 1'b0;
    IR_enable  = 1'b0;
    Y_enable   = 1'b0;
    Z_enable   = 1'b0;
    HI_enable  = 1'b0;
    LO_enable  = 1'b0;
    opcode     = 5'd0;
    illegal    = 1'b0;
    r_out_on   = 1'b0;
    r_out_idx  = 4'd0;
    r_en_on    = 1'b0;
    r_en_idx   = 4'd0;
    run        = (state_reg != S_IDLE) && (state_reg != S_HALT);
    case (state_reg)
      S_T0: begin
        PC_out     = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        PC_enable  = 1'b1;
      end
      S_T1: begin
        Read       = 1'b1;
        MDR_enable = 1'b1;
      end
      S_T2: begin
        MDR_out   = 1'b1;
        IR_enable = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_ALU:  begin r_out_on = 1'b1; r_out_idx = rb; Y_enable = 1'b1; end
          C_MD:   begin r_out_on = 1'b1; r_out_idx = ra; Y_enable = 1'b1; end
          C_NN:   begin r_out_on = 1'b1; r_out_idx = rb; opcode = op; Z_enable = 1'b1; end
          C_MFHI: begin HI_out = 1'b1; r_en_on = 1'b1; r_en_idx = ra; end
          C_MFLO: begin LO_out = 1'b1; r_en_on = 1'b1; r_en_idx = ra; end
          C_ILL:  illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU: begin r_out_on = 1'b1; r_out_idx = rc; opcode = op; Z_enable = 1'b1; end
          C_MD:  begin r_out_on = 1'b1; r_out_idx = rb; opcode = op; Z_enable = 1'b1; end
          C_NN:  begin ZLow_out = 1'b1; r_en_on = 1'b1; r_en_idx = ra; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU: begin ZLow_out = 1'b1; r_en_on = 1'b1; r_en_idx = ra; end
          C_MD:  begin ZLow_out = 1'b1; LO_enable = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        if (cls == C_MD) begin
          ZHigh_out = 1'b1;
          HI_enable = 1'b1;
        end
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_rsel
      assign R_out[gi]    = r_out_on && (r_out_idx == 4'(gi));
      assign R_enable[gi] = r_en_on  && (r_en_idx  == 4'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_control_unit.sv
// Random and directed instruction streams checked step-by-step against a
// table model of the per-class strobe sequences.
module tb_control_unit;

  localparam int CW = 8;

  logic clk;
  logic clr;
  logic [31:0] ir;
  logic PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out;
  logic [15:0] R_out, R_enable;
  logic MAR_enable, PC_enable, IncPC, Read, MDR_enable, IR_enable;
  logic Y_enable, Z_enable, HI_enable, LO_enable;
  logic [4:0] opcode;
  logic run, illegal;
  logic [CW-1:0] instr_count;

  control_unit #(.NREG(16), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .ir(ir),
    .PC_out(PC_out), .MDR_out(MDR_out), .ZLow_out(ZLow_out), .ZHigh_out(ZHigh_out),
    .HI_out(HI_out), .LO_out(LO_out), .R_out(R_out), .R_enable(R_enable),
    .MAR_enable(MAR_enable), .PC_enable(PC_enable), .IncPC(IncPC), .Read(Read),
    .MDR_enable(MDR_enable), .IR_enable(IR_enable), .Y_enable(Y_enable),
    .Z_enable(Z_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
    .opcode(opcode), .run(run), .illegal(illegal), .instr_count(instr_count)
  );

  typedef struct packed {
    logic [5:0]  src;
    logic [9:0]  ld;
    logic        ill;
    logic        rn;
    logic [4:0]  opc;
    logic [15:0] rout;
    logic [15:0] ren;
  } strobe_t;

  localparam logic [5:0] S_PC  = 6'b100000;
  localparam logic [5:0] S_MDR = 6'b010000;
  localparam logic [5:0] S_ZL  = 6'b001000;
  localparam logic [5:0] S_ZH  = 6'b000100;
  localparam logic [5:0] S_HI  = 6'b000010;
  localparam logic [5:0] S_LO  = 6'b000001;
  localparam logic [9:0] L_MAR = 10'b1000000000;
  localparam logic [9:0] L_PC  = 10'b0100000000;
  localparam logic [9:0] L_INC = 10'b0010000000;
  localparam logic [9:0] L_RD  = 10'b0001000000;
  localparam logic [9:0] L_MDR = 10'b0000100000;
  localparam logic [9:0] L_IR  = 10'b0000010000;
  localparam logic [9:0] L_Y   = 10'b0000001000;
  localparam logic [9:0] L_Z   = 10'b0000000100;
  localparam logic [9:0] L_HI  = 10'b0000000010;
  localparam logic [9:0] L_LO  = 10'b0000000001;

  int n_checks = 0;
  int n_fail = 0;
  int exp_count = 0;
  strobe_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic strobe_t actual();
    strobe_t t;
    t.src  = {PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out};
    t.ld   = {MAR_enable, PC_enable, IncPC, Read, MDR_enable, IR_enable,
              Y_enable, Z_enable, HI_enable, LO_enable};
    t.ill  = illegal;
    t.rn   = run;
    t.opc  = opcode;
    t.rout = R_out;
    t.ren  = R_enable;
    return t;
  endfunction

  function automatic strobe_t st(logic [5:0] s, logic [9:0] l, logic [4:0] o,
                                 logic [15:0] ro, logic [15:0] re, logic il);
    strobe_t t;
    t.src = s; t.ld = l; t.ill = il; t.rn = 1'b1; t.opc = o; t.rout = ro; t.ren = re;
    return t;
  endfunction

  function automatic logic [15:0] oh(logic [3:0] i);
    return 16'h0001 << i;
  endfunction

  task automatic do_reset();
    strobe_t zero;
    zero = '0;
    clr = 1'b0;
    #1;
    exp_count = 0;
    check("rst_out", 64'(zero), 64'(actual()));
    check("rst_cnt", 64'(instr_count), 64'(exp_count));
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    check("idle_out", 64'(actual()), 64'(zero));
    @(posedge clk); #1;
  endtask

  // Entered #1 after the edge into T0; abort_at >= 0 pulls clr low at that step.
  task automatic run_instr(input logic [31:0] instr, input int abort_at);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    strobe_t zero;
    zero = '0;
    op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
    exp_q.delete();
    exp_q.push_back(st(S_PC, L_MAR | L_PC | L_INC, 5'd0, 16'd0, 16'd0, 1'b0));
    exp_q.push_back(st(6'd0, L_RD | L_MDR, 5'd0, 16'd0, 16'd0, 1'b0));
    exp_q.push_back(st(S_MDR, L_IR, 5'd0, 16'd0, 16'd0, 1'b0));
    if (op >= 5'd3 && op <= 5'd12) begin
      exp_q.push_back(st(6'd0, L_Y, 5'd0, oh(rb), 16'd0, 1'b0));
      exp_q.push_back(st(6'd0, L_Z, op, oh(rc), 16'd0, 1'b0));
      exp_q.push_back(st(S_ZL, 10'd0, 5'd0, 16'd0, oh(ra), 1'b0));
    end else if (op == 5'd15 || op == 5'd16) begin
      exp_q.push_back(st(6'd0, L_Y, 5'd0, oh(ra), 16'd0, 1'b0));
      exp_q.push_back(st(6'd0, L_Z, op, oh(rb), 16'd0, 1'b0));
      exp_q.push_back(st(S_ZL, L_LO, 5'd0, 16'd0, 16'd0, 1'b0));
      exp_q.push_back(st(S_ZH, L_HI, 5'd0, 16'd0, 16'd0, 1'b0));
    end else if (op == 5'd17 || op == 5'd18) begin
      exp_q.push_back(st(6'd0, L_Z, op, oh(rb), 16'd0, 1'b0));
      exp_q.push_back(st(S_ZL, 10'd0, 5'd0, 16'd0, oh(ra), 1'b0));
    end else if (op == 5'd23) begin
      exp_q.push_back(st(S_HI, 10'd0, 5'd0, 16'd0, oh(ra), 1'b0));
    end else if (op == 5'd24) begin
      exp_q.push_back(st(S_LO, 10'd0, 5'd0, 16'd0, oh(ra), 1'b0));
    end else if (op == 5'd26 || op == 5'd27) begin
      exp_q.push_back(st(6'd0, 10'd0, 5'd0, 16'd0, 16'd0, 1'b0));
    end else begin
      exp_q.push_back(st(6'd0, 10'd0, 5'd0, 16'd0, 16'd0, 1'b1));
    end

    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("op%0d_step%0d", op, i), 64'(actual()), 64'(exp_q[i]));
      if (i == 0) check($sformatf("op%0d_count", op), 64'(instr_count), 64'(exp_count));
      if (i == abort_at) begin
        do_reset();
        return;
      end
      @(posedge clk); #1;
      if (i == 2) ir = instr;
    end

    if (op == 5'd27) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        check($sformatf("halt_out%0d", k), 64'(actual()), 64'(zero));
        check($sformatf("halt_cnt%0d", k), 64'(instr_count), 64'(exp_count));
      end
      @(posedge clk); #1;
    end else begin
      exp_count = (exp_count + 1) % (1 << CW);
    end
  endtask

  initial begin
    logic [31:0] instr;
    clr = 1'b1;
    ir  = 32'd0;
    #2;
    do_reset();

    run_instr(32'h2022_8000, -1);                          // sub R0,R4,R5
    run_instr({5'b01111, 4'd2, 4'd3, 19'd0}, -1);          // mul R2,R3
    run_instr({5'b11000, 4'd7, 23'd0}, -1);                // mflo R7
    run_instr({5'b11111, 27'd0}, -1);                      // undefined op
    run_instr({5'b10001, 4'd9, 4'd15, 19'd0}, -1);         // neg

    for (int n = 0; n < 60; n++) begin
      instr = $urandom();
      if (instr[31:27] == 5'd27) instr[31:27] = 5'd26;
      run_instr(instr, -1);
    end

    run_instr({5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, 4);     // add, clr in T4

    while (exp_count != (1 << CW) - 1) run_instr({5'b11010, 27'd0}, -1);
    run_instr({5'b11010, 27'd0}, -1);                      // wraps to 0
    run_instr({5'b11010, 27'd0}, -1);                      // observes wrapped count

    run_instr({5'b11011, 27'd0}, -1);                      // halt
    do_reset();
    run_instr({5'b11010, 27'd0}, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
